// File: rtl/wf_slot_dispatcher_pkg.sv
// wf_dispatch_pkg: shared FSM state, wavefront tag layout and tag pack/unpack helpers.
package wf_dispatch_pkg;
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE} state_t;
  localparam int TAG_W = 15;
  localparam int SLOT_LSB = 0;
  localparam int SLOT_W = 5;
  localparam int CU_LSB = 5;
  localparam int CU_W = 4;
  function automatic logic [TAG_W-1:0] pack_tag(input logic [CU_W-1:0] cu, input logic [SLOT_W-1:0] slot);
    return {{(TAG_W-CU_W-SLOT_W){1'b0}}, cu, slot};
  endfunction
  function automatic logic [CU_W-1:0] tag_cu(input logic [TAG_W-1:0] t);
    return t[CU_LSB +: CU_W];
  endfunction
  function automatic logic [SLOT_W-1:0] tag_slot(input logic [TAG_W-1:0] t);
    return t[SLOT_LSB +: SLOT_W];
  endfunction
endpackage

// File: rtl/wf_slot_dispatcher_if.sv
// wf_slot_dispatcher_if: launch request handshake, CU dispatch bus and per-CU done/status signals.
interface wf_slot_dispatcher_if import wf_dispatch_pkg::*; #(parameter int NUMOFCU = 1);
  logic                     req_valid;
  logic                     req_ready;
  logic [31:0]              req_pc;
  logic [5:0]               req_wf_size;
  logic [3:0]               req_wg_wf_count;
  logic [9:0]               req_vgpr_size;
  logic [8:0]               req_sgpr_size;
  logic [15:0]              req_lds_size;
  logic                     req_error;
  logic [NUMOFCU-1:0]       dispatch2cu_wf_dispatch;
  logic [3:0]               dispatch2cu_wg_wf_count;
  logic [5:0]               dispatch2cu_wf_size_dispatch;
  logic [8:0]               dispatch2cu_sgpr_base_dispatch;
  logic [9:0]               dispatch2cu_vgpr_base_dispatch;
  logic [15:0]              dispatch2cu_lds_base_dispatch;
  logic [TAG_W-1:0]         dispatch2cu_wf_tag_dispatch;
  logic [31:0]              dispatch2cu_start_pc_dispatch;
  logic [9:0]               vregsize_out;
  logic [8:0]               sregsize_out;
  logic [15:0]              ldssize_out;
  logic [NUMOFCU-1:0]       cu2dispatch_wf_done;
  logic [NUMOFCU*TAG_W-1:0] cu2dispatch_wf_tag_done;
  logic [9:0]               wf_inflight;
  logic                     tag_error;
  modport master (
    output req_valid, req_pc, req_wf_size, req_wg_wf_count, req_vgpr_size, req_sgpr_size, req_lds_size,
    output cu2dispatch_wf_done, cu2dispatch_wf_tag_done,
    input  req_ready, req_error, dispatch2cu_wf_dispatch, dispatch2cu_wg_wf_count, dispatch2cu_wf_size_dispatch,
    input  dispatch2cu_sgpr_base_dispatch, dispatch2cu_vgpr_base_dispatch, dispatch2cu_lds_base_dispatch,
    input  dispatch2cu_wf_tag_dispatch, dispatch2cu_start_pc_dispatch, vregsize_out, sregsize_out, ldssize_out,
    input  wf_inflight, tag_error
  );
  modport slave (
    input  req_valid, req_pc, req_wf_size, req_wg_wf_count, req_vgpr_size, req_sgpr_size, req_lds_size,
    input  cu2dispatch_wf_done, cu2dispatch_wf_tag_done,
    output req_ready, req_error, dispatch2cu_wf_dispatch, dispatch2cu_wg_wf_count, dispatch2cu_wf_size_dispatch,
    output dispatch2cu_sgpr_base_dispatch, dispatch2cu_vgpr_base_dispatch, dispatch2cu_lds_base_dispatch,
    output dispatch2cu_wf_tag_dispatch, dispatch2cu_start_pc_dispatch, vregsize_out, sregsize_out, ldssize_out,
    output wf_inflight, tag_error
  );
endinterface

// File: rtl/wf_slot_dispatcher_picker.sv
// rr_free_slot_picker: first CU with a free slot starting at rr (wrapping), lowest free slot in it.
module rr_free_slot_picker import wf_dispatch_pkg::*; #(
  parameter int NUMOFCU = 1,
  parameter int SLOTS_PER_CU = 8
) (
  input  logic [NUMOFCU-1:0][SLOTS_PER_CU-1:0] busy,
  input  logic [CU_W-1:0]                      rr,
  output logic                                 found,
  output logic [CU_W-1:0]                      cu,
  output logic [SLOT_W-1:0]                    slot
);
  always_comb begin
    found = 1'b0;
    cu = '0;
    slot = '0;
    for (int i = 0; i < NUMOFCU; i++)
      for (int n = 0; n < NUMOFCU; n++)
        if (!found && n == (int'(rr) + i) % NUMOFCU && !(&busy[n])) begin
          found = 1'b1;
          cu = CU_W'(n);
          for (int s = SLOTS_PER_CU - 1; s >= 0; s--)
            if (!busy[n][s]) slot = SLOT_W'(s);
        end
  end
endmodule

// File: rtl/wf_slot_dispatcher.sv
// wf_slot_dispatcher: round-robin wavefront launcher over NUMOFCU CUs with static per-slot register/LDS partitions.
module wf_slot_dispatcher import wf_dispatch_pkg::*; #(
  parameter int NUMOFCU = 1,
  parameter int SLOTS_PER_CU = 8,
  parameter int VGPR_SLOT = 128,
  parameter int SGPR_SLOT = 64,
  parameter int LDS_SLOT = 8192
) (
  input logic clk,
  input logic rst,
  wf_slot_dispatcher_if.slave bus
);
  localparam int SW = $clog2(SLOTS_PER_CU);
  state_t state;
  logic [NUMOFCU-1:0][SLOTS_PER_CU-1:0] busy, busy_nxt;
  logic [CU_W-1:0] rr, pick_cu, sel_cu;
  logic [SLOT_W-1:0] pick_slot;
  logic found, done_err, oversize;
  logic [TAG_W-1:0] done_tag [NUMOFCU];
  logic [31:0] r_pc;
  logic [5:0] r_wf_size;
  logic [3:0] r_wgc;
  logic [9:0] r_vgpr;
  logic [8:0] r_sgpr;
  logic [15:0] r_lds;
  rr_free_slot_picker #(.NUMOFCU(NUMOFCU), .SLOTS_PER_CU(SLOTS_PER_CU)) u_pick (
    .busy(busy), .rr(rr), .found(found), .cu(pick_cu), .slot(pick_slot)
  );
  for (genvar g = 0; g < NUMOFCU; g++) begin : g_tag
    assign done_tag[g] = bus.cu2dispatch_wf_tag_done[g*TAG_W +: TAG_W];
  end
  assign oversize = bus.req_vgpr_size > 10'(VGPR_SLOT) || bus.req_sgpr_size > 9'(SGPR_SLOT) ||
                    bus.req_lds_size > 16'(LDS_SLOT);
  // Dones clear against the current bitmap; SELECT only ever claims slots that are free before the clear.
  always_comb begin
    busy_nxt = busy;
    done_err = 1'b0;
    for (int n = 0; n < NUMOFCU; n++)
      if (bus.cu2dispatch_wf_done[n]) begin
        if (tag_cu(done_tag[n]) != CU_W'(n) || int'(tag_slot(done_tag[n])) >= SLOTS_PER_CU ||
            !busy[n][SW'(tag_slot(done_tag[n]))])
          done_err = 1'b1;
        else
          busy_nxt[n][SW'(tag_slot(done_tag[n]))] = 1'b0;
      end
    for (int n = 0; n < NUMOFCU; n++)
      if (state == SELECT && found && pick_cu == CU_W'(n)) busy_nxt[n][SW'(pick_slot)] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      bus.wf_inflight <= '0;
      bus.tag_error <= 1'b0;
    end else begin
      busy <= busy_nxt;
      bus.wf_inflight <= 10'($countones(busy_nxt));
      bus.tag_error <= bus.tag_error | done_err;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      sel_cu <= '0;
      {r_pc, r_wf_size, r_wgc, r_vgpr, r_sgpr, r_lds} <= '0;
      bus.req_ready <= 1'b0;
      bus.req_error <= 1'b0;
      bus.dispatch2cu_wf_dispatch <= '0;
      bus.dispatch2cu_wg_wf_count <= '0;
      bus.dispatch2cu_wf_size_dispatch <= '0;
      bus.dispatch2cu_sgpr_base_dispatch <= '0;
      bus.dispatch2cu_vgpr_base_dispatch <= '0;
      bus.dispatch2cu_lds_base_dispatch <= '0;
      bus.dispatch2cu_wf_tag_dispatch <= '0;
      bus.dispatch2cu_start_pc_dispatch <= '0;
      bus.vregsize_out <= '0;
      bus.sregsize_out <= '0;
      bus.ldssize_out <= '0;
    end else begin
      bus.req_error <= 1'b0;
      bus.dispatch2cu_wf_dispatch <= '0;
      case (state)
        IDLE: begin
          bus.req_ready <= !(bus.req_valid && bus.req_ready && !oversize);
          if (bus.req_valid && bus.req_ready) begin
            r_pc <= bus.req_pc;
            r_wf_size <= bus.req_wf_size;
            r_wgc <= bus.req_wg_wf_count;
            r_vgpr <= bus.req_vgpr_size;
            r_sgpr <= bus.req_sgpr_size;
            r_lds <= bus.req_lds_size;
            bus.req_error <= oversize;
            state <= oversize ? IDLE : SELECT;
          end
        end
        SELECT: if (found) begin
          state <= ISSUE;
          sel_cu <= pick_cu;
          for (int n = 0; n < NUMOFCU; n++) bus.dispatch2cu_wf_dispatch[n] <= pick_cu == CU_W'(n);
          bus.dispatch2cu_wg_wf_count <= r_wgc;
          bus.dispatch2cu_wf_size_dispatch <= r_wf_size;
          bus.dispatch2cu_sgpr_base_dispatch <= 9'(SGPR_SLOT * int'(pick_slot));
          bus.dispatch2cu_vgpr_base_dispatch <= 10'(VGPR_SLOT * int'(pick_slot));
          bus.dispatch2cu_lds_base_dispatch <= 16'(LDS_SLOT * int'(pick_slot));
          bus.dispatch2cu_wf_tag_dispatch <= pack_tag(pick_cu, pick_slot);
          bus.dispatch2cu_start_pc_dispatch <= r_pc;
          bus.vregsize_out <= r_vgpr;
          bus.sregsize_out <= r_sgpr;
          bus.ldssize_out <= r_lds;
        end
        ISSUE: begin
          state <= IDLE;
          bus.req_ready <= 1'b1;
          rr <= sel_cu == CU_W'(NUMOFCU - 1) ? '0 : sel_cu + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wf_slot_dispatcher.sv
// tb_wf_slot_dispatcher: directed checks of dispatch order, stalls, dones, oversize drop and reset abort (2 CUs).
module tb_wf_slot_dispatcher;
  import wf_dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  wf_slot_dispatcher_if #(.NUMOFCU(2)) bus ();
  wf_slot_dispatcher #(.NUMOFCU(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  // Returns just after the accepting edge (DUT in SELECT, or IDLE for a dropped request).
  task automatic send(input logic [31:0] pc, input logic [9:0] v, input logic [8:0] s, input logic [15:0] l);
    bit acc = 0;
    bus.req_pc = pc;
    bus.req_vgpr_size = v;
    bus.req_sgpr_size = s;
    bus.req_lds_size = l;
    bus.req_wf_size = 6'd63;
    bus.req_wg_wf_count = 4'd1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask
  task automatic done(input logic [1:0] d, input logic [14:0] t1, input logic [14:0] t0);
    bus.cu2dispatch_wf_done = d;
    bus.cu2dispatch_wf_tag_done = {t1, t0};
    tick();
    bus.cu2dispatch_wf_done = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.req_wf_size = '0;
    bus.req_wg_wf_count = '0;
    bus.req_vgpr_size = '0;
    bus.req_sgpr_size = '0;
    bus.req_lds_size = '0;
    bus.cu2dispatch_wf_done = '0;
    bus.cu2dispatch_wf_tag_done = '0;
    tick();
    tick();
    check("rst_ready", bus.req_ready, 0);
    check("rst_strobe", bus.dispatch2cu_wf_dispatch, 0);
    check("rst_inflight", bus.wf_inflight, 0);
    check("rst_tag_error", bus.tag_error, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", bus.req_ready, 1);
    // single request
    send(32'h100, 10'd64, 9'd32, 16'd512);
    check("t1_no_early_strobe", bus.dispatch2cu_wf_dispatch, 0);
    check("t1_ready_low", bus.req_ready, 0);
    tick();
    check("t1_strobe", bus.dispatch2cu_wf_dispatch, 2'b01);
    check("t1_tag", bus.dispatch2cu_wf_tag_dispatch, 0);
    check("t1_vbase", bus.dispatch2cu_vgpr_base_dispatch, 0);
    check("t1_sbase", bus.dispatch2cu_sgpr_base_dispatch, 0);
    check("t1_lbase", bus.dispatch2cu_lds_base_dispatch, 0);
    check("t1_pc", bus.dispatch2cu_start_pc_dispatch, 32'h100);
    check("t1_vsize", bus.vregsize_out, 64);
    check("t1_ssize", bus.sregsize_out, 32);
    check("t1_lsize", bus.ldssize_out, 512);
    check("t1_wfsize", bus.dispatch2cu_wf_size_dispatch, 63);
    check("t1_wgc", bus.dispatch2cu_wg_wf_count, 1);
    check("t1_inflight", bus.wf_inflight, 1);
    tick();
    check("t1_strobe_1cyc", bus.dispatch2cu_wf_dispatch, 0);
    check("t1_ready_back", bus.req_ready, 1);
    // back-to-back, boundary sizes accepted
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_oh;
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      send(32'h200 + 32'(i), 10'd128, 9'd64, 16'd8192);
      tick();
      check($sformatf("t2_strobe%0d", i), bus.dispatch2cu_wf_dispatch, exp_oh);
      check($sformatf("t2_tag%0d", i), bus.dispatch2cu_wf_tag_dispatch, pack_tag(4'(i % 2), 5'(i / 2)));
      check($sformatf("t2_vbase%0d", i), bus.dispatch2cu_vgpr_base_dispatch, (i < 2) ? 0 : 128);
    end
    tick();
    check("t2_inflight", bus.wf_inflight, 4);
    done(2'b11, 15'h021, 15'h001);
    check("t3_inflight_drop2", bus.wf_inflight, 2);
    check("t3_no_tag_error", bus.tag_error, 0);
    done(2'b01, 15'h000, 15'h001);
    check("t3_tag_error", bus.tag_error, 1);
    check("t3_inflight_same", bus.wf_inflight, 2);
    tick();
    check("t3_tag_error_sticky", bus.tag_error, 1);
    // oversize request dropped
    do_reset();
    send(32'h300, 10'd129, 9'd32, 16'd512);
    check("t4_req_error", bus.req_error, 1);
    check("t4_ready", bus.req_ready, 1);
    tick();
    check("t4_error_pulse", bus.req_error, 0);
    check("t4_no_strobe", bus.dispatch2cu_wf_dispatch, 0);
    tick();
    check("t4_no_strobe2", bus.dispatch2cu_wf_dispatch, 0);
    check("t4_inflight", bus.wf_inflight, 0);
    // fill every slot, then stall
    for (int i = 0; i < 16; i++) begin
      send(32'h400, 10'd1, 9'd1, 16'd1);
      tick();
      check($sformatf("t5_tag%0d", i), bus.dispatch2cu_wf_tag_dispatch, pack_tag(4'(i % 2), 5'(i / 2)));
    end
    send(32'h500, 10'd1, 9'd1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_stall_strobe", bus.dispatch2cu_wf_dispatch, 0);
    end
    check("t5_stall_ready", bus.req_ready, 0);
    check("t5_full_inflight", bus.wf_inflight, 16);
    done(2'b01, 15'h000, 15'h003);
    check("t5_done_no_strobe", bus.dispatch2cu_wf_dispatch, 0);
    check("t5_inflight15", bus.wf_inflight, 15);
    tick();
    check("t5_strobe", bus.dispatch2cu_wf_dispatch, 2'b01);
    check("t5_tag3", bus.dispatch2cu_wf_tag_dispatch, 15'h003);
    check("t5_vbase3", bus.dispatch2cu_vgpr_base_dispatch, 384);
    check("t5_sbase3", bus.dispatch2cu_sgpr_base_dispatch, 192);
    check("t5_lbase3", bus.dispatch2cu_lds_base_dispatch, 24576);
    check("t5_pc", bus.dispatch2cu_start_pc_dispatch, 32'h500);
    check("t5_inflight16", bus.wf_inflight, 16);
    // reset during stall aborts
    send(32'h600, 10'd1, 9'd1, 16'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_strobe", bus.dispatch2cu_wf_dispatch, 0);
    check("t6_rst_inflight", bus.wf_inflight, 0);
    check("t6_rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    tick();
    check("t6_ready", bus.req_ready, 1);
    check("t6_inflight", bus.wf_inflight, 0);
    tick();
    check("t6_no_strobe", bus.dispatch2cu_wf_dispatch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
